// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode: stores up to DEPTH fetched words with
// predecoded hazard fields and presents the oldest one or two for (dual) issue.
module decode_queue #(
  parameter int DEPTH      = 8,
  parameter int DUAL_ISSUE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr0,
  input  logic [31:0]            in_instr1,
  output logic                   in_ready,
  output logic [1:0]             out_valid,
  output logic [31:0]            out_pc0,
  output logic [31:0]            out_pc1,
  output logic [31:0]            out_instr0,
  output logic [31:0]            out_instr1,
  output logic [4:0]             out_dst0,
  output logic [4:0]             out_dst1,
  output logic                   out_wen0,
  output logic                   out_wen1,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0] dst;
    logic       wen;
    logic       use_rs;
    logic       use_rt;
    logic       br;
    logic       mem;
    logic       hilo;
    logic       solo;
  } pd_t;

  function automatic pd_t predecode(input logic [5:0] op, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [5:0] fn);
    pd_t        p;
    logic [4:0] d;
    logic       w;
    p = '0;
    d = 5'd0;
    w = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03: begin
            w = 1'b1; d = rd; p.use_rt = 1'b1;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            w = 1'b1; d = rd; p.use_rs = 1'b1; p.use_rt = 1'b1;
          end
          6'h08: begin
            p.use_rs = 1'b1; p.br = 1'b1;
          end
          6'h09: begin
            w = 1'b1; d = rd; p.use_rs = 1'b1; p.br = 1'b1;
          end
          6'h10, 6'h12: begin
            w = 1'b1; d = rd; p.hilo = 1'b1;
          end
          6'h11, 6'h13: begin
            p.use_rs = 1'b1; p.hilo = 1'b1;
          end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            p.use_rs = 1'b1; p.use_rt = 1'b1; p.hilo = 1'b1;
          end
          // SYSCALL, BREAK and unknown functions serialise.
          default: p.solo = 1'b1;
        endcase
      end
      6'h01: begin
        p.use_rs = 1'b1; p.br = 1'b1;
        if (rt[4]) begin
          w = 1'b1; d = 5'd31;
        end
      end
      6'h02: p.br = 1'b1;
      6'h03: begin
        p.br = 1'b1; w = 1'b1; d = 5'd31;
      end
      6'h04, 6'h05: begin
        p.use_rs = 1'b1; p.use_rt = 1'b1; p.br = 1'b1;
      end
      6'h06, 6'h07: begin
        p.use_rs = 1'b1; p.br = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        p.use_rs = 1'b1; w = 1'b1; d = rt;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        p.use_rs = 1'b1; p.mem = 1'b1; w = 1'b1; d = rt;
      end
      6'h28, 6'h29, 6'h2b: begin
        p.use_rs = 1'b1; p.use_rt = 1'b1; p.mem = 1'b1;
      end
      default: p.solo = 1'b1;
    endcase
    p.dst = d;
    p.wen = w && (d != 5'd0);
    return p;
  endfunction

  // Entry storage carries no reset; validity is defined by head/count alone.
  pd_t         r_pd    [DEPTH];
  logic [31:0] r_pc    [DEPTH];
  logic [31:0] r_instr [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [1:0]    w_npush;
  logic [1:0]    w_npop;
  pd_t           w_pd0;
  pd_t           w_pd1;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rt1;
  logic          w_raw;
  logic          w_waw;
  logic          w_pair_ok;

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);

  assign w_pd0 = predecode(in_instr0[31:26], in_instr0[20:16], in_instr0[15:11], in_instr0[5:0]);
  assign w_pd1 = predecode(in_instr1[31:26], in_instr1[20:16], in_instr1[15:11], in_instr1[5:0]);

  // Issue side: purely from registered entries and count.
  assign w_rs1 = r_instr[w_head1][25:21];
  assign w_rt1 = r_instr[w_head1][20:16];

  assign w_raw = r_pd[r_head].wen &&
                 ((r_pd[w_head1].use_rs && (w_rs1 == r_pd[r_head].dst)) ||
                  (r_pd[w_head1].use_rt && (w_rt1 == r_pd[r_head].dst)));
  assign w_waw = r_pd[r_head].wen && r_pd[w_head1].wen &&
                 (r_pd[r_head].dst == r_pd[w_head1].dst);

  assign w_pair_ok = !w_raw && !w_waw &&
                     !(r_pd[r_head].mem && r_pd[w_head1].mem) &&
                     !(r_pd[r_head].hilo && r_pd[w_head1].hilo) &&
                     !r_pd[r_head].solo && !r_pd[w_head1].solo &&
                     !r_pd[w_head1].br;

  assign out_valid[0] = (r_count != CW'(0));
  assign out_valid[1] = (DUAL_ISSUE != 0) && (r_count >= CW'(2)) && w_pair_ok;

  assign out_pc0    = r_pc[r_head];
  assign out_pc1    = r_pc[w_head1];
  assign out_instr0 = r_instr[r_head];
  assign out_instr1 = r_instr[w_head1];
  assign out_dst0   = r_pd[r_head].dst;
  assign out_dst1   = r_pd[w_head1].dst;
  assign out_wen0   = r_pd[r_head].wen;
  assign out_wen1   = r_pd[w_head1].wen;
  assign count      = r_count;

  // Readiness uses the pre-pop count so it never depends on out_ready.
  assign in_ready = (r_count <= CW'(DEPTH - 2));

  assign w_npush = (in_ready && in_valid[0]) ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
  assign w_npop  = out_ready ? ({1'b0, out_valid[1]} + {1'b0, out_valid[0]}) : 2'd0;

  always_ff @(posedge clk) begin
    if (!flush && (w_npush != 2'd0)) begin
      r_pc[r_tail]    <= in_pc;
      r_instr[r_tail] <= in_instr0;
      r_pd[r_tail]    <= w_pd0;
      if (w_npush == 2'd2) begin
        r_pc[w_tail1]    <= in_pc + 32'd4;
        r_instr[w_tail1] <= in_instr1;
        r_pd[w_tail1]    <= w_pd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_npop);
      r_tail  <= r_tail + AW'(w_npush);
      r_count <= r_count + CW'(w_npush) - CW'(w_npop);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed pairing/fill/flush/reset steps plus random traffic,
// checked against a mnemonic-level queue model for a dual- and a single-issue instance.
module tb_decode_queue;

  localparam int DEPTH = 8;

  localparam int K_ADDU = 0,  K_SLL = 1,  K_JR = 2,    K_JALR = 3,    K_MFHI = 4;
  localparam int K_MTLO = 5,  K_MULT = 6, K_SYSC = 7,  K_ADDIU = 8,   K_LUI = 9;
  localparam int K_LW = 10,   K_SW = 11,  K_BEQ = 12,  K_BLEZ = 13,   K_J = 14;
  localparam int K_JAL = 15,  K_BGEZAL = 16, K_BLTZ = 17, K_COP0 = 18, K_BAD = 19;
  localparam int NK = 20;

  // dsel: 0 writes nothing, 1 rd, 2 rt, 3 r31
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         dsel;
    bit         urs, urt, br, mem, hilo, solo;
  } info_t;

  typedef struct {
    int          k;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, out_ready;
  logic [1:0]  in_valid;
  logic [31:0] in_pc, in_instr0, in_instr1;

  logic        rdy_a, rdy_b, w0_a, w1_a, w0_b, w1_b;
  logic [1:0]  ov_a, ov_b;
  logic [31:0] p0_a, p1_a, i0_a, i1_a, p0_b, p1_b, i0_b, i1_b;
  logic [4:0]  d0_a, d1_a, d0_b, d1_b;
  logic [3:0]  cnt_a, cnt_b;

  int          checks = 0;
  int          errors = 0;
  ent_t        qa[$];
  ent_t        qb[$];
  logic [31:0] gpc = 32'h0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .DUAL_ISSUE(1)) u_dual (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_ready(rdy_a), .out_valid(ov_a),
    .out_pc0(p0_a), .out_pc1(p1_a), .out_instr0(i0_a), .out_instr1(i1_a),
    .out_dst0(d0_a), .out_dst1(d1_a), .out_wen0(w0_a), .out_wen1(w1_a),
    .out_ready(out_ready), .count(cnt_a)
  );

  decode_queue #(.DEPTH(DEPTH), .DUAL_ISSUE(0)) u_single (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_ready(rdy_b), .out_valid(ov_b),
    .out_pc0(p0_b), .out_pc1(p1_b), .out_instr0(i0_b), .out_instr1(i1_b),
    .out_dst0(d0_b), .out_dst1(d1_b), .out_wen0(w0_b), .out_wen1(w1_b),
    .out_ready(out_ready), .count(cnt_b)
  );

  function automatic info_t kinfo(input int k);
    info_t i;
    i.op = 6'h00; i.fn = 6'h00; i.dsel = 0;
    i.urs = 0; i.urt = 0; i.br = 0; i.mem = 0; i.hilo = 0; i.solo = 0;
    case (k)
      K_ADDU:   begin i.fn = 6'h21; i.dsel = 1; i.urs = 1; i.urt = 1; end
      K_SLL:    begin i.fn = 6'h00; i.dsel = 1; i.urt = 1; end
      K_JR:     begin i.fn = 6'h08; i.urs = 1; i.br = 1; end
      K_JALR:   begin i.fn = 6'h09; i.dsel = 1; i.urs = 1; i.br = 1; end
      K_MFHI:   begin i.fn = 6'h10; i.dsel = 1; i.hilo = 1; end
      K_MTLO:   begin i.fn = 6'h13; i.urs = 1; i.hilo = 1; end
      K_MULT:   begin i.fn = 6'h18; i.urs = 1; i.urt = 1; i.hilo = 1; end
      K_SYSC:   begin i.fn = 6'h0c; i.solo = 1; end
      K_ADDIU:  begin i.op = 6'h09; i.dsel = 2; i.urs = 1; end
      K_LUI:    begin i.op = 6'h0f; i.dsel = 2; i.urs = 1; end
      K_LW:     begin i.op = 6'h23; i.dsel = 2; i.urs = 1; i.mem = 1; end
      K_SW:     begin i.op = 6'h2b; i.urs = 1; i.urt = 1; i.mem = 1; end
      K_BEQ:    begin i.op = 6'h04; i.urs = 1; i.urt = 1; i.br = 1; end
      K_BLEZ:   begin i.op = 6'h06; i.urs = 1; i.br = 1; end
      K_J:      begin i.op = 6'h02; i.br = 1; end
      K_JAL:    begin i.op = 6'h03; i.dsel = 3; i.br = 1; end
      K_BGEZAL: begin i.op = 6'h01; i.dsel = 3; i.urs = 1; i.br = 1; end
      K_BLTZ:   begin i.op = 6'h01; i.urs = 1; i.br = 1; end
      K_COP0:   begin i.op = 6'h10; i.solo = 1; end
      default:  begin i.op = 6'h3f; i.solo = 1; end
    endcase
    return i;
  endfunction

  function automatic ent_t mk(input int k, input int rs, input int rt, input int rd, input int imm);
    ent_t e;
    e.k = k; e.rs = 5'(rs); e.rt = 5'(rt); e.rd = 5'(rd); e.imm = 16'(imm); e.pc = 32'h0;
    if (k == K_BGEZAL) e.rt = 5'd17;
    if (k == K_BLTZ)   e.rt = 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] enc(input ent_t e);
    info_t i;
    i = kinfo(e.k);
    if (i.op == 6'h00) return {6'h00, e.rs, e.rt, e.rd, 5'd0, i.fn};
    return {i.op, e.rs, e.rt, e.imm};
  endfunction

  function automatic int edst(input ent_t e);
    case (kinfo(e.k).dsel)
      1:       return int'(e.rd);
      2:       return int'(e.rt);
      3:       return 31;
      default: return 0;
    endcase
  endfunction

  function automatic bit ewen(input ent_t e);
    return (kinfo(e.k).dsel != 0) && (edst(e) != 0);
  endfunction

  function automatic bit pair_ok(input ent_t a, input ent_t b);
    info_t ia, ib;
    ia = kinfo(a.k);
    ib = kinfo(b.k);
    if (ewen(a) && ((ib.urs && int'(b.rs) == edst(a)) || (ib.urt && int'(b.rt) == edst(a)))) return 0;
    if (ewen(a) && ewen(b) && edst(a) == edst(b)) return 0;
    if (ia.mem && ib.mem) return 0;
    if (ia.hilo && ib.hilo) return 0;
    if (ia.solo || ib.solo || ib.br) return 0;
    return 1;
  endfunction

  function automatic logic [1:0] exp_ov(input ent_t q[$], input bit dual);
    if (q.size() == 0) return 2'b00;
    if (dual && q.size() >= 2 && pair_ok(q[0], q[1])) return 2'b11;
    return 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic [3:0] cnt, input logic rdy,
                           input logic [1:0] ov, input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] i0, input logic [31:0] i1, input logic [4:0] d0,
                           input logic [4:0] d1, input logic w0, input logic w1,
                           input ent_t q[$], input bit dual);
    chk({nm, "_count"}, 32'(cnt), 32'(q.size()));
    chk({nm, "_in_ready"}, 32'(rdy), 32'((DEPTH - q.size()) >= 2));
    chk({nm, "_out_valid"}, 32'(ov), 32'(exp_ov(q, dual)));
    if (q.size() >= 1) begin
      chk({nm, "_pc0"}, p0, q[0].pc);
      chk({nm, "_instr0"}, i0, enc(q[0]));
      chk({nm, "_wen0"}, 32'(w0), 32'(ewen(q[0])));
      if (kinfo(q[0].k).dsel != 0) chk({nm, "_dst0"}, 32'(d0), 32'(edst(q[0])));
    end
    if (q.size() >= 2) begin
      chk({nm, "_pc1"}, p1, q[1].pc);
      chk({nm, "_instr1"}, i1, enc(q[1]));
      chk({nm, "_wen1"}, 32'(w1), 32'(ewen(q[1])));
      if (kinfo(q[1].k).dsel != 0) chk({nm, "_dst1"}, 32'(d1), 32'(edst(q[1])));
    end
  endtask

  task automatic check_all();
    check_dut("dual", cnt_a, rdy_a, ov_a, p0_a, p1_a, i0_a, i1_a, d0_a, d1_a, w0_a, w1_a, qa, 1'b1);
    check_dut("single", cnt_b, rdy_b, ov_b, p0_b, p1_b, i0_b, i1_b, d0_b, d1_b, w0_b, w1_b, qb, 1'b0);
  endtask

  // Drive one cycle of inputs, advance both models, check at the following negedge.
  task automatic do_cycle(input logic [1:0] iv, input ent_t e0, input ent_t e1,
                          input logic ordy, input logic fl);
    ent_t q[$];
    logic [1:0] ov;
    bit   ready;
    e0.pc = gpc;
    e1.pc = gpc + 32'd4;
    gpc   = gpc + 32'd8;
    in_valid  = iv;
    in_pc     = e0.pc;
    in_instr0 = enc(e0);
    in_instr1 = enc(e1);
    out_ready = ordy;
    flush     = fl;
    for (int w = 0; w < 2; w++) begin
      if (w == 0) q = qa; else q = qb;
      if (fl) begin
        q.delete();
      end else begin
        ready = (DEPTH - q.size()) >= 2;
        if (ordy) begin
          ov = exp_ov(q, w == 0);
          repeat (int'(ov[0]) + int'(ov[1])) void'(q.pop_front());
        end
        if (ready && iv[0]) begin
          q.push_back(e0);
          if (iv[1]) q.push_back(e1);
        end
      end
      if (w == 0) qa = q; else qb = q;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t nop;
    ent_t r0, r1;
    logic [1:0] iv;
    nop = mk(K_ADDU, 0, 0, 0, 0);
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 2'b00;
    in_pc = 32'h0; in_instr0 = 32'h0; in_instr1 = 32'h0;

    @(negedge clk);
    chk("reset_count", 32'(cnt_a), 32'd0);
    chk("reset_out_valid", 32'(ov_a), 32'd0);
    chk("reset_in_ready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Independent pair of ALU-immediates.
    gpc = 32'hbfc00000;
    do_cycle(2'b11, mk(K_ADDIU, 0, 1, 0, 5), mk(K_ADDIU, 0, 2, 0, 7), 1'b0, 1'b0);
    chk("t1_out_valid", 32'(ov_a), 32'h3);
    chk("t1_instr0", i0_a, 32'h24010005);
    chk("t1_pc1", p1_a, 32'hbfc00004);
    chk("t1_dst0", 32'(d0_a), 32'd1);
    chk("t1_dst1", 32'(d1_a), 32'd2);
    chk("t1_wen", 32'({w0_a, w1_a}), 32'h3);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);
    chk("t1_drained", 32'(cnt_a), 32'd0);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);

    // RAW: addu reads the register the addiu writes.
    do_cycle(2'b11, mk(K_ADDIU, 0, 3, 0, 1), mk(K_ADDU, 3, 3, 4, 0), 1'b0, 1'b0);
    chk("raw_out_valid", 32'(ov_a), 32'h1);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);
    chk("raw_second_valid", 32'(ov_a), 32'h1);
    chk("raw_second_dst", 32'(d0_a), 32'd4);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);

    do_cycle(2'b11, mk(K_LW, 6, 5, 0, 0), mk(K_SW, 6, 7, 0, 4), 1'b0, 1'b0);
    chk("mem_pair", 32'(ov_a), 32'h1);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);

    do_cycle(2'b11, mk(K_BEQ, 1, 2, 0, 8), mk(K_ADDIU, 0, 8, 0, 1), 1'b0, 1'b0);
    chk("branch_delay_pair", 32'(ov_a), 32'h3);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);

    do_cycle(2'b11, mk(K_ADDU, 1, 2, 9, 0), mk(K_JR, 31, 0, 0, 0), 1'b0, 1'b0);
    chk("branch_slot1", 32'(ov_a), 32'h1);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);
    do_cycle(2'b00, nop, nop, 1'b1, 1'b0);

    do_cycle(2'b11, mk(K_SYSC, 0, 0, 0, 0), mk(K_ADDIU, 0, 10, 0, 3), 1'b0, 1'b0);
    chk("solo_first", 32'(ov_a), 32'h1);
    do_cycle(2'b00, nop, nop, 1'b0, 1'b1);

    // Fill without popping: ready drops once fewer than two slots remain.
    do_cycle(2'b11, mk(K_ADDIU, 0, 1, 0, 1), mk(K_ADDIU, 0, 2, 0, 2), 1'b0, 1'b0);
    do_cycle(2'b11, mk(K_ADDIU, 0, 3, 0, 3), mk(K_ADDIU, 0, 4, 0, 4), 1'b0, 1'b0);
    do_cycle(2'b11, mk(K_ADDIU, 0, 5, 0, 5), mk(K_ADDIU, 0, 6, 0, 6), 1'b0, 1'b0);
    chk("fill_ready_at6", 32'(rdy_a), 32'd1);
    do_cycle(2'b01, mk(K_ADDIU, 0, 7, 0, 7), nop, 1'b0, 1'b0);
    chk("fill_count7", 32'(cnt_a), 32'd7);
    chk("fill_ready_at7", 32'(rdy_a), 32'd0);
    do_cycle(2'b11, mk(K_ADDIU, 0, 8, 0, 8), mk(K_ADDIU, 0, 9, 0, 9), 1'b0, 1'b0);
    chk("fill_drop", 32'(cnt_a), 32'd7);

    // Flush at count 5 with a simultaneous push and pop request.
    do_cycle(2'b00, nop, nop, 1'b0, 1'b1);
    do_cycle(2'b11, mk(K_ADDU, 1, 2, 3, 0), mk(K_ADDU, 4, 5, 6, 0), 1'b0, 1'b0);
    do_cycle(2'b11, mk(K_ADDU, 1, 2, 7, 0), mk(K_ADDU, 4, 5, 8, 0), 1'b0, 1'b0);
    do_cycle(2'b01, mk(K_ADDU, 1, 2, 9, 0), nop, 1'b0, 1'b0);
    chk("flush_pre_count", 32'(cnt_a), 32'd5);
    do_cycle(2'b11, mk(K_ADDU, 1, 2, 3, 0), mk(K_ADDU, 4, 5, 6, 0), 1'b1, 1'b1);
    chk("flush_count", 32'(cnt_a), 32'd0);
    chk("flush_out_valid", 32'(ov_a), 32'd0);

    // Random traffic across pointer wrap.
    for (int c = 0; c < 200; c++) begin
      case ($urandom_range(0, 2))
        0:       iv = 2'b00;
        1:       iv = 2'b01;
        default: iv = 2'b11;
      endcase
      r0 = mk(int'($urandom_range(0, NK - 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      r1 = mk(int'($urandom_range(0, NK - 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      do_cycle(iv, r0, r1, ($urandom_range(0, 9) < 7), 1'b0);
      chk("single_no_slot1", 32'(ov_b[1]), 32'd0);
    end

    // Asynchronous reset between clock edges.
    do_cycle(2'b11, mk(K_ADDIU, 0, 1, 0, 1), mk(K_ADDIU, 0, 2, 0, 2), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_count", 32'(cnt_a), 32'd0);
    chk("async_reset_valid", 32'(ov_a), 32'd0);
    chk("async_reset_count_single", 32'(cnt_b), 32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    reset = 1'b0;
    check_all();
    do_cycle(2'b11, mk(K_LUI, 0, 11, 0, 1), mk(K_ADDU, 1, 2, 12, 0), 1'b0, 1'b0);
    chk("post_reset_count", 32'(cnt_a), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
